// File: rtl/ms_pkg.sv
// Shared types and helpers for the multi-stream block arbiter.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds the arbiter state encoding, the tag-width helper and the reset block length.
package ms_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BLOCK = 1'b1
    } arb_state_t;

    localparam int LEN_DEF = 23;

    function automatic int tag_w(input int flux);
        return (flux > 2) ? $clog2(flux) : 1;
    endfunction

endpackage

// File: rtl/ms_flow_fifo.sv
// Per-flow synchronous FIFO with registered full/empty flags.
// Latency: a push is visible at dout one cycle later (fall-through read of the head entry).
// Backpressure: writes while full are dropped unless a pop happens in the same cycle.
module ms_flow_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          do_push;
    logic          do_pop;

    // A pop frees the slot this cycle, so a concurrent push at full is kept.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ms_block_arbiter.sv
// N-flow front end: per-flow FIFOs, round-robin grant of whole blocks to one output; MS_ARB_STATS_EN adds counters.
// Latency: pop in cycle t -> out_write/out_din in t+1; one idle bubble between blocks.
// Backpressure: out_full stalls the granted flow (no mid-block switch); in_full drops writes.
module ms_block_arbiter #(
    parameter int   FLUX    = 4,
    parameter int   DW      = 8,
    parameter int   DEPTH   = 16,
    parameter int   LENW    = 7,
    parameter int   LEN_DEF = ms_pkg::LEN_DEF,
    localparam int  TAGW    = ms_pkg::tag_w(FLUX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLUX*DW-1:0]   in_din,
    input  logic [FLUX-1:0]      in_write,
    output logic [FLUX-1:0]      in_full,
    input  logic [TAGW+LENW-1:0] cfg_din,
    input  logic                 cfg_write,
    output logic                 cfg_err,
    output logic [TAGW+DW-1:0]   out_din,
    output logic                 out_write,
    input  logic                 out_full,
`ifdef MS_ARB_STATS_EN
    input  logic [TAGW-1:0]      stat_sel,
    output logic [31:0]          stat_tok,
    output logic [31:0]          stat_stall,
`endif
    output logic                 busy
);

    import ms_pkg::*;

    arb_state_t      state;
    logic [TAGW-1:0] ptr;
    logic [TAGW-1:0] cur;
    logic [LENW-1:0] cnt;
    logic [LENW-1:0] len_q [FLUX];
    logic [FLUX-1:0] fifo_empty;
    logic [FLUX-1:0] fifo_pop;
    logic [DW-1:0]   fifo_dout [FLUX];
    logic            pop;
    logic            found;
    logic [TAGW-1:0] pick;
    logic [TAGW-1:0] cfg_tag;
    logic [LENW-1:0] cfg_len;

    assign {cfg_tag, cfg_len} = cfg_din;

    for (genvar g = 0; g < FLUX; g++) begin : g_flow
        ms_flow_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_write[g]),
            .din   (in_din[g*DW +: DW]),
            .pop   (fifo_pop[g]),
            .dout  (fifo_dout[g]),
            .full  (in_full[g]),
            .empty (fifo_empty[g])
        );
    end

    assign pop = (state == ARB_BLOCK) && !fifo_empty[cur] && !out_full;

    always_comb begin
        fifo_pop      = '0;
        fifo_pop[cur] = pop;
    end

    // Walk backwards so the flow closest to ptr is the last (winning) assignment.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        for (int i = FLUX - 1; i >= 0; i--) begin
            logic [TAGW-1:0] idx;
            idx = TAGW'((int'(ptr) + i) % FLUX);
            if (!fifo_empty[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            cur       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            out_write <= 1'b0;
            out_din   <= '0;
        end else begin
            out_write <= pop;
            if (pop) out_din <= {cur, fifo_dout[cur]};
            case (state)
                ARB_IDLE: begin
                    if (found) begin
                        cur   <= pick;
                        cnt   <= len_q[pick];
                        state <= ARB_BLOCK;
                        busy  <= 1'b1;
                    end
                end
                ARB_BLOCK: begin
                    if (pop) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == LENW'(1)) begin
                            ptr   <= (cur == TAGW'(FLUX - 1)) ? '0 : cur + 1'b1;
                            state <= ARB_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Length registers are read only at grant time, so an in-flight block keeps its count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int f = 0; f < FLUX; f++) len_q[f] <= LENW'(LEN_DEF);
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (cfg_write && (int'(cfg_tag) < FLUX)) begin
                if (cfg_len == '0) cfg_err <= 1'b1;
                else               len_q[cfg_tag] <= cfg_len;
            end
        end
    end

`ifdef MS_ARB_STATS_EN
    logic [31:0] tok_cnt   [FLUX];
    logic [31:0] stall_cnt [FLUX];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int f = 0; f < FLUX; f++) begin
                tok_cnt[f]   <= '0;
                stall_cnt[f] <= '0;
            end
        end else begin
            for (int f = 0; f < FLUX; f++) begin
                if (pop && (cur == TAGW'(f)) && (tok_cnt[f] != '1))
                    tok_cnt[f] <= tok_cnt[f] + 1'b1;
                if ((state == ARB_BLOCK) && !pop && (cur == TAGW'(f)) && (stall_cnt[f] != '1))
                    stall_cnt[f] <= stall_cnt[f] + 1'b1;
            end
        end
    end

    assign stat_tok   = (int'(stat_sel) < FLUX) ? tok_cnt[stat_sel]   : '0;
    assign stat_stall = (int'(stat_sel) < FLUX) ? stall_cnt[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_ms_block_arbiter.sv
// Randomized and directed bench for ms_block_arbiter against a queue-based reference model.
// Checks every cycle: out_write/out_din, busy, in_full and cfg_err; plus block-level order and length.
module tb_ms_block_arbiter;

    localparam int FLUX  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LENW  = 7;
    localparam int TAGW  = 2;

    logic                 clk;
    logic                 rst;
    logic [FLUX*DW-1:0]   in_din;
    logic [FLUX-1:0]      in_write;
    logic [FLUX-1:0]      in_full;
    logic [TAGW+LENW-1:0] cfg_din;
    logic                 cfg_write;
    logic                 cfg_err;
    logic [TAGW+DW-1:0]   out_din;
    logic                 out_write;
    logic                 out_full;
    logic                 busy;
`ifdef MS_ARB_STATS_EN
    logic [TAGW-1:0]      stat_sel;
    logic [31:0]          stat_tok;
    logic [31:0]          stat_stall;
`endif

    ms_block_arbiter #(.FLUX(FLUX), .DW(DW), .DEPTH(DEPTH), .LENW(LENW), .LEN_DEF(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_din    (in_din),
        .in_write  (in_write),
        .in_full   (in_full),
        .cfg_din   (cfg_din),
        .cfg_write (cfg_write),
        .cfg_err   (cfg_err),
        .out_din   (out_din),
        .out_write (out_write),
        .out_full  (out_full),
`ifdef MS_ARB_STATS_EN
        .stat_sel  (stat_sel),
        .stat_tok  (stat_tok),
        .stat_stall(stat_stall),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: per-flow token queues plus block-level grant bookkeeping.
    logic [7:0]          q [FLUX][$];
    bit                  m_blk;
    int                  m_f, m_rem, m_ptr;
    int                  m_len [FLUX];
    logic                m_ow;
    logic [TAGW+DW-1:0]  m_od;
    logic                m_err;

    // Observed block records.
    int  blk_len [$];
    int  blk_tag [$];
    int  rec_cnt;
    int  rec_tag;
    bit  prev_busy;

    task automatic model_reset();
        for (int f = 0; f < FLUX; f++) begin
            q[f].delete();
            m_len[f] = 23;
        end
        m_blk = 0; m_f = 0; m_rem = 0; m_ptr = 0;
        m_ow = 1'b0; m_od = '0; m_err = 1'b0;
    endtask

    task automatic model_step();
        int sz [FLUX];
        bit p;
        int tag, len;
        for (int f = 0; f < FLUX; f++) sz[f] = q[f].size();
        p = m_blk && (sz[m_f] > 0) && !out_full;
        m_ow = p;
        if (p) m_od = {TAGW'(m_f), q[m_f].pop_front()};
        for (int f = 0; f < FLUX; f++)
            if (in_write[f] && (sz[f] < DEPTH || (p && f == m_f)))
                q[f].push_back(in_din[f*DW +: DW]);
        if (!m_blk) begin
            for (int i = 0; i < FLUX; i++) begin
                if (!m_blk && sz[(m_ptr + i) % FLUX] > 0) begin
                    m_blk = 1;
                    m_f   = (m_ptr + i) % FLUX;
                    m_rem = m_len[m_f];
                end
            end
        end else if (p) begin
            m_rem--;
            if (m_rem == 0) begin
                m_blk = 0;
                m_ptr = (m_f + 1) % FLUX;
            end
        end
        m_err = 1'b0;
        if (cfg_write) begin
            tag = int'(cfg_din[LENW +: TAGW]);
            len = int'(cfg_din[LENW-1:0]);
            if (tag < FLUX) begin
                if (len == 0) m_err = 1'b1;
                else          m_len[tag] = len;
            end
        end
    endtask

    function automatic bit all_empty();
        for (int f = 0; f < FLUX; f++) if (q[f].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        logic [FLUX-1:0] exp_full;
        if (!rst) model_reset(); else model_step();
        @(posedge clk);
        #1;
        for (int f = 0; f < FLUX; f++) exp_full[f] = (q[f].size() == DEPTH);
        chk("out_write", 32'(out_write), 32'(m_ow));
        chk("out_din",   32'(out_din),   32'(m_od));
        chk("busy",      32'(busy),      32'(m_blk));
        chk("in_full",   32'(in_full),   32'(exp_full));
        chk("cfg_err",   32'(cfg_err),   32'(m_err));
        if (!rst) begin
            rec_cnt = 0;
        end else begin
            if (out_write) begin
                rec_cnt++;
                rec_tag = int'(out_din[DW +: TAGW]);
            end
            if (prev_busy && !busy) begin
                blk_len.push_back(rec_cnt);
                blk_tag.push_back(rec_tag);
                rec_cnt = 0;
            end
        end
        prev_busy = busy;
        in_write  = '0;
        cfg_write = 1'b0;
    endtask

    function automatic bit try_push(input int f, input logic [7:0] v);
        if (q[f].size() >= DEPTH) return 1'b0;
        in_write[f] = 1'b1;
        in_din[f*DW +: DW] = v;
        return 1'b1;
    endfunction

    function automatic int rec_len(input int i);
        return (i < blk_len.size()) ? blk_len[i] : -1;
    endfunction

    function automatic int rec_tg(input int i);
        return (i < blk_tag.size()) ? blk_tag[i] : -1;
    endfunction

    task automatic clear_rec();
        blk_len.delete();
        blk_tag.delete();
        rec_cnt = 0;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        out_full = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        clear_rec();
    endtask

    // Run until the model is idle with empty queues, topping up the granted flow if it starves.
    task automatic drain();
        int c = 0;
        out_full = 1'b0;
        while ((m_blk || !all_empty()) && c < 3000) begin
            if (m_blk && q[m_f].size() == 0) begin
                in_write[m_f] = 1'b1;
                in_din[m_f*DW +: DW] = 8'($urandom);
            end
            tick();
            c++;
        end
        chk("drain_done", 32'(c < 3000), 32'd1);
    endtask

    task automatic cfg(input int tag, input int len);
        cfg_write = 1'b1;
        cfg_din   = {TAGW'(tag), LENW'(len)};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent [FLUX];
        int cnt;
        bit busy_left;
        rst = 1'b0; in_din = '0; in_write = '0; cfg_din = '0; cfg_write = 1'b0; out_full = 1'b0;
        prev_busy = 0;
`ifdef MS_ARB_STATS_EN
        stat_sel = '0;
`endif
        repeat (2) tick();
        rst = 1'b1;
        clear_rec();

        // 1: single flow, one full block of 0x00..0x16
        cnt = 0;
        for (int c = 0; c < 300 && cnt < 23; c++) begin
            if (try_push(2, 8'(cnt))) cnt++;
            tick();
        end
        drain();
        chk("t1_nblk", 32'(blk_len.size()), 32'd1);
        chk("t1_len",  32'(rec_len(0)), 32'd23);
        chk("t1_tag",  32'(rec_tg(0)), 32'd2);
        clear_rec();
        void'(try_push(0, 8'hA0));
        void'(try_push(3, 8'hA3));
        tick();
        drain();
        chk("t1_ptr_next", 32'(rec_tg(0)), 32'd3);
        chk("t1_ptr_wrap", 32'(rec_tg(1)), 32'd0);

        // 2: all flows loaded, round-robin of whole blocks
        reset_dut();
        for (int f = 0; f < FLUX; f++) sent[f] = 0;
        for (int c = 0; c < 3000; c++) begin
            busy_left = 0;
            for (int f = 0; f < FLUX; f++) begin
                if (sent[f] < 46) begin
                    busy_left = 1;
                    if (try_push(f, 8'(f * 64 + sent[f]))) sent[f]++;
                end
            end
            if (!busy_left) break;
            tick();
        end
        drain();
        chk("t2_nblk", 32'(blk_len.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk("t2_len", 32'(rec_len(k)), 32'd23);
            chk("t2_tag", 32'(rec_tg(k)), 32'(k % FLUX));
        end

        // 3: downstream full for 5 cycles mid-block of flow 1
        reset_dut();
        out_full = 1'b1;
        for (int i = 0; i < 16; i++) begin
            void'(try_push(1, 8'(8'h40 + i)));
            tick();
        end
        out_full = 1'b0;
        cnt = 16;
        for (int i = 0; i < 8; i++) begin
            if (cnt < 23 && try_push(1, 8'(8'h40 + cnt))) cnt++;
            tick();
        end
        out_full = 1'b1;
        cnt = 0;
        repeat (5) begin
            tick();
            if (out_write) cnt++;
        end
        chk("t3_stall_writes_le1", 32'(cnt <= 1), 32'd1);
        drain();
        chk("t3_len", 32'(rec_len(0)), 32'd23);

        // 4: overfill flow 0, then push concurrently with a pop
        reset_dut();
        out_full = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_write[0] = 1'b1;
            in_din[DW-1:0] = 8'(8'h10 + i);
            tick();
        end
        chk("t4_full", 32'(in_full[0]), 32'd1);
        out_full = 1'b0;
        in_write[0] = 1'b1;
        in_din[DW-1:0] = 8'hEE;
        tick();
        chk("t4_full_kept", 32'(in_full[0]), 32'd1);
        drain();
        chk("t4_len", 32'(rec_len(0)), 32'd23);

        // 5: zero-length config rejected; new length applies at the next grant
        reset_dut();
        cfg(1, 0);
        tick();
        chk("t5_err_pulse", 32'(cfg_err), 32'd1);
        tick();
        chk("t5_err_clear", 32'(cfg_err), 32'd0);
        cnt = 0;
        for (int c = 0; c < 200 && cnt < 31; c++) begin
            if (c == 15) cfg(1, 8);
            if (try_push(1, 8'(cnt))) cnt++;
            tick();
        end
        drain();
        chk("t5_len_cur",  32'(rec_len(0)), 32'd23);
        chk("t5_len_next", 32'(rec_len(1)), 32'd8);

        // 6: reset mid-block restores lengths, pointer and empties FIFOs
        cfg(0, 5);
        tick();
        for (int i = 0; i < 10; i++) begin
            void'(try_push(3, 8'(i)));
            tick();
        end
        rst = 1'b0;
        tick();
`ifdef MS_ARB_STATS_EN
        for (int s = 0; s < FLUX; s++) begin
            stat_sel = TAGW'(s);
            #1;
            chk("t6_stat_tok",   stat_tok,   32'd0);
            chk("t6_stat_stall", stat_stall, 32'd0);
        end
`endif
        tick();
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_full", 32'(in_full), 32'd0);
        chk("t6_ow",   32'(out_write), 32'd0);
        rst = 1'b1;
        clear_rec();
        void'(try_push(1, 8'h61));
        void'(try_push(0, 8'h60));
        tick();
        drain();
        chk("t6_tag", 32'(rec_tg(0)), 32'd0);
        chk("t6_len", 32'(rec_len(0)), 32'd23);
`ifdef MS_ARB_STATS_EN
        stat_sel = '0;
        #1;
        chk("t6_stat_tok0", stat_tok, 32'd23);
`endif

        // Random traffic with backpressure, overflow and reconfiguration
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            for (int f = 0; f < FLUX; f++) begin
                if ($urandom_range(0, 99) < 35) begin
                    in_write[f] = 1'b1;
                    in_din[f*DW +: DW] = 8'($urandom);
                end
            end
            out_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
